// File: rtl/multi_flex_counter_pkg.sv
// Shared types and defaults for the multi-channel flexible counter.
package multi_flex_counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;

endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: pure next-state and wrap-condition logic; the top holds the state.
module flex_counter_ch
    import multi_flex_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] rollover,
    input  dir_e             dir,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_cond
);

    always_comb begin
        next_count = count;
        wrap_cond  = 1'b0;
        if (clear) begin
            next_count = '0;
        end else if (enable) begin
            if (dir == DIR_UP) begin
                // Counts above a freshly lowered terminal value wrap straight to 0.
                if (count >= rollover) begin
                    next_count = '0;
                    wrap_cond  = 1'b1;
                end else begin
                    next_count = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    next_count = rollover;
                    wrap_cond  = 1'b1;
                end else if (count > rollover) begin
                    next_count = rollover;
                end else begin
                    next_count = count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_flex_counter.sv
// CHANNELS independent up/down counters with per-channel terminal value.
// Define MULTI_FLEX_COUNTER_CASCADE_EN to gate channel k>0 by channel k-1's same-edge wrap.
module multi_flex_counter
    import multi_flex_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       count_enable,
    input  logic [CHANNELS-1:0]       down,
    input  logic [CHANNELS*WIDTH-1:0] rollover_val,
    output logic [CHANNELS*WIDTH-1:0] count_out,
    output logic [CHANNELS-1:0]       wrap_pulse
);

    logic [CHANNELS-1:0][WIDTH-1:0] count;
    logic [CHANNELS-1:0][WIDTH-1:0] next_count;
    logic [CHANNELS-1:0][WIDTH-1:0] rollover;
    logic [CHANNELS-1:0]            enable;
    logic [CHANNELS-1:0]            wrap_cond;

    assign rollover  = rollover_val;
    assign count_out = count;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic             wrap_q;

        if (k == 0) begin : g_head
            assign enable[k] = count_enable[k];
        end else begin : g_gate
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
            // Combinational wrap of the lower channel, so the cascade steps on the same edge.
            assign enable[k] = count_enable[k] & wrap_cond[k-1];
`else
            assign enable[k] = count_enable[k];
`endif
        end

        flex_counter_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .count     (count[k]),
            .rollover  (rollover[k]),
            .dir       (dir_e'(down[k])),
            .clear     (clear[k]),
            .enable    (enable[k]),
            .next_count(next_count[k]),
            .wrap_cond (wrap_cond[k])
        );

        always_ff @(posedge clk) begin
            if (!nrst) begin
                cnt_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                cnt_q  <= next_count[k];
                wrap_q <= wrap_cond[k];
            end
        end

        assign count[k]      = cnt_q;
        assign wrap_pulse[k] = wrap_q;
    end

endmodule

// File: tb/tb_multi_flex_counter.sv
// Directed-vector bench for multi_flex_counter (WIDTH=4, CHANNELS=2).
module tb_multi_flex_counter;

    localparam int W = 4;
    localparam int C = 2;

    logic           clk;
    logic           nrst;
    logic [C-1:0]   clear;
    logic [C-1:0]   count_enable;
    logic [C-1:0]   down;
    logic [C*W-1:0] rollover_val;
    logic [C*W-1:0] count_out;
    logic [C-1:0]   wrap_pulse;

    int n_chk;
    int n_bad;

    multi_flex_counter #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .clear       (clear),
        .count_enable(count_enable),
        .down        (down),
        .rollover_val(rollover_val),
        .count_out   (count_out),
        .wrap_pulse  (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
    endtask

    task automatic ch0(input string tag, input int cnt, input int wrp);
        chk({tag, "_cnt"}, 32'(count_out[W-1:0]), 32'(cnt));
        chk({tag, "_wrap"}, 32'(wrap_pulse[0]), 32'(wrp));
    endtask

    initial begin
        int exp_up[6];
        int exp_dn[5];
        int exp_dw[5];
        n_chk = 0;
        n_bad = 0;
        nrst = 1'b0;
        clear = '0;
        count_enable = '0;
        down = '0;
        rollover_val = '0;

        // Reset state
        step();
        step();
        chk("rst_cnt", 32'(count_out), 32'h0);
        chk("rst_wrap", 32'(wrap_pulse), 32'h0);

        // Up, rollover 5: 1,2,3,4,5,0 (wrap shows with the 0)
        exp_up = '{1, 2, 3, 4, 5, 0};
        rollover_val = {4'd0, 4'd5};
        count_enable = 2'b01;
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            ch0($sformatf("up5_%0d", i), exp_up[i], (i == 5) ? 1 : 0);
        end
        step();
        ch0("up5_after", 1, 0);
        chk("up5_ch1_hold", 32'(count_out[2*W-1:W]), 32'h0);

        // Down, rollover 3 from reset: 3,2,1,0,3 with wrap on each 0->3
        do_reset();
        down = 2'b01;
        rollover_val = {4'd0, 4'd3};
        exp_dn = '{3, 2, 1, 0, 3};
        exp_dw = '{1, 0, 0, 0, 1};
        for (int i = 0; i < 5; i++) begin
            step();
            ch0($sformatf("dn3_%0d", i), exp_dn[i], exp_dw[i]);
        end

        // Count at 9, rollover lowered to 4, up: 0 with wrap
        count_enable = '0;
        do_reset();
        down = 2'b00;
        rollover_val = {4'd0, 4'd15};
        count_enable = 2'b01;
        repeat (9) step();
        ch0("at9_up", 9, 0);
        rollover_val = {4'd0, 4'd4};
        step();
        ch0("lower_up", 0, 1);

        // Count at 9, rollover lowered to 4, down: 4 without wrap, then 3
        do_reset();
        rollover_val = {4'd0, 4'd15};
        repeat (9) step();
        down = 2'b01;
        rollover_val = {4'd0, 4'd4};
        step();
        ch0("lower_dn", 4, 0);
        step();
        ch0("lower_dn_next", 3, 0);

        // Rollover 0: stays 0 and wraps every enabled edge
        down = 2'b00;
        rollover_val = '0;
        step();
        ch0("roll0_a", 0, 1);
        step();
        ch0("roll0_b", 0, 1);

        // Clear beats enable at a would-be wrap point (count 7, rollover 7)
        do_reset();
        rollover_val = {4'd0, 4'd7};
        repeat (7) step();
        ch0("at7", 7, 0);
        clear = 2'b01;
        step();
        ch0("clear", 0, 0);
        clear = 2'b00;
        step();
        ch0("clear_resume", 1, 0);

        // Hold: enable dropped keeps count, wrap low
        count_enable = 2'b00;
        step();
        ch0("hold", 1, 0);

        // Reset mid-count overrides everything
        count_enable = 2'b11;
        rollover_val = {4'd9, 4'd9};
        step();
        nrst = 1'b0;
        clear = 2'b10;
        step();
        chk("midrst_cnt", 32'(count_out), 32'h0);
        chk("midrst_wrap", 32'(wrap_pulse), 32'h0);

        // Two channels, rollover 3/2, both enabled up, for 12 edges
        nrst = 1'b1;
        clear = '0;
        down = '0;
        count_enable = '0;
        do_reset();
        rollover_val = {4'd2, 4'd3};
        count_enable = 2'b11;
        for (int n = 1; n <= 12; n++) begin
            step();
            chk($sformatf("dual_c0_%0d", n), 32'(count_out[W-1:0]), 32'(n % 4));
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
            chk($sformatf("dual_c1_%0d", n), 32'(count_out[2*W-1:W]), 32'((n / 4) % 3));
            chk($sformatf("dual_w1_%0d", n), 32'(wrap_pulse[1]), 32'((n == 12) ? 1 : 0));
`else
            chk($sformatf("dual_c1_%0d", n), 32'(count_out[2*W-1:W]), 32'(n % 3));
            chk($sformatf("dual_w1_%0d", n), 32'(wrap_pulse[1]), 32'((n % 3 == 0) ? 1 : 0));
`endif
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
